// File: rtl/axi_rd_resp_router.sv
// In-order read-return router: queues the slave index of each accepted read address and steers
// R beats from the head slave to the master. Optional burst-length checking: AXI_RD_RESP_LEN_CHECK_EN.
module axi_rd_resp_router #(
  parameter int DEPTH = 4,
  parameter int DW    = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     a_fire,
  input  logic [2:0]               a_sel,
  input  logic [7:0]               a_len,
  output logic                     a_full,
  input  logic [5*DW-1:0]          s_rdata,
  input  logic [9:0]               s_rresp,
  input  logic [4:0]               s_rlast,
  input  logic [4:0]               s_rvalid,
  output logic [4:0]               s_rready,
  output logic [DW-1:0]            m_rdata,
  output logic [1:0]               m_rresp,
  output logic                     m_rlast,
  output logic                     m_rvalid,
  input  logic                     m_rready,
  output logic [$clog2(DEPTH):0]   outstanding,
  output logic                     err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int NS = 5;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  // Outstanding-burst FIFO; read side is combinational so the head steers the same cycle.
  logic [2:0]    sel_mem [DEPTH];
  logic [7:0]    len_mem [DEPTH];
  logic [PW-1:0] wr_ptr_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic          err_reg;

  logic [2:0]    sel_mapped;
  logic          push;
  logic          overflow;
  logic          not_empty;
  logic [2:0]    head_sel;
  logic [7:0]    head_len;
  logic          beat_fire;
  logic          pop;
  logic          len_err;

  logic [NS-1:0] head_hit;
  logic [DW-1:0] data_masked [NS];
  logic [1:0]    resp_masked [NS];

  assign sel_mapped = (a_sel > 3'd4) ? 3'd0 : a_sel;
  assign a_full     = (count_reg == FULL_CNT);
  assign push       = a_fire && !a_full;
  assign overflow   = a_fire && a_full;
  assign not_empty  = (count_reg != '0);
  assign head_sel   = sel_mem[rd_ptr_reg];
  assign head_len   = len_mem[rd_ptr_reg];
  assign outstanding = count_reg;
  assign err        = err_reg;

  // Per-slave one-hot select; only the head slave sees the master's ready.
  genvar gi;
  generate
    for (gi = 0; gi < NS; gi++) begin : g_slave
      assign head_hit[gi]    = not_empty && (head_sel == 3'(gi));
      assign s_rready[gi]    = head_hit[gi] && m_rready;
      assign data_masked[gi] = {DW{head_hit[gi]}} & s_rdata[gi*DW +: DW];
      assign resp_masked[gi] = {2{head_hit[gi]}} & s_rresp[2*gi +: 2];
    end
  endgenerate

  always_comb begin
    m_rdata = '0;
    m_rresp = '0;
    for (int i = 0; i < NS; i++) begin
      m_rdata = m_rdata | data_masked[i];
      m_rresp = m_rresp | resp_masked[i];
    end
  end

  assign m_rvalid  = |(head_hit & s_rvalid);
  assign m_rlast   = |(head_hit & s_rlast);
  assign beat_fire = m_rvalid && m_rready;
  assign pop       = beat_fire && m_rlast;

  // Entry storage carries no reset; validity is tracked by count_reg alone.
  always_ff @(posedge clk) begin
    if (push) begin
      sel_mem[wr_ptr_reg] <= sel_mapped;
      len_mem[wr_ptr_reg] <= a_len;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

`ifdef AXI_RD_RESP_LEN_CHECK_EN
  logic [7:0] beat_cnt_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      beat_cnt_reg <= '0;
    end else if (pop) begin
      beat_cnt_reg <= '0;
    end else if (beat_fire) begin
      beat_cnt_reg <= beat_cnt_reg + 8'd1;
    end
  end

  // Early or late rlast relative to the recorded burst length.
  assign len_err = beat_fire &&
                   ((m_rlast && (beat_cnt_reg != head_len)) ||
                    (!m_rlast && (beat_cnt_reg == head_len)));
`else
  logic len_unused;
  assign len_unused = ^head_len;
  assign len_err    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      err_reg <= 1'b0;
    end else if (overflow || len_err) begin
      err_reg <= 1'b1;
    end
  end

endmodule

// File: tb/tb_axi_rd_resp_router.sv
// Scoreboard bench for axi_rd_resp_router: expected beats are queued when a slave beat is driven
// and compared when the master side fires.
module tb_axi_rd_resp_router;

  localparam int DEPTH = 4;
  localparam int DW    = 32;

  logic                   clk;
  logic                   reset;
  logic                   a_fire;
  logic [2:0]             a_sel;
  logic [7:0]             a_len;
  logic                   a_full;
  logic [5*DW-1:0]        s_rdata;
  logic [9:0]             s_rresp;
  logic [4:0]             s_rlast;
  logic [4:0]             s_rvalid;
  logic [4:0]             s_rready;
  logic [DW-1:0]          m_rdata;
  logic [1:0]             m_rresp;
  logic                   m_rlast;
  logic                   m_rvalid;
  logic                   m_rready;
  logic [$clog2(DEPTH):0] outstanding;
  logic                   err;

  axi_rd_resp_router #(.DEPTH(DEPTH), .DW(DW)) dut (
    .clk(clk), .reset(reset),
    .a_fire(a_fire), .a_sel(a_sel), .a_len(a_len), .a_full(a_full),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
    .s_rvalid(s_rvalid), .s_rready(s_rready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
    .m_rvalid(m_rvalid), .m_rready(m_rready),
    .outstanding(outstanding), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [1:0]    resp;
    logic          last;
  } beat_t;

  beat_t exp_q[$];
  int tests_run    = 0;
  int tests_failed = 0;

`ifdef AXI_RD_RESP_LEN_CHECK_EN
  localparam logic LEN_ERR_EXP = 1'b1;
`else
  localparam logic LEN_ERR_EXP = 1'b0;
`endif

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Master-side monitor: every fired beat must match the head of the scoreboard.
  always @(negedge clk) begin
    beat_t e;
    if (!reset && m_rvalid && m_rready) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_beat", 64'(m_rdata), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        $display("[TB] beat data=0x%08h resp=%0d last=%0b", m_rdata, m_rresp, m_rlast);
        check("m_rdata", 64'(m_rdata), 64'(e.data));
        check("m_rresp", 64'(m_rresp), 64'(e.resp));
        check("m_rlast", 64'(m_rlast), 64'(e.last));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    a_fire   = 1'b0;
    a_sel    = '0;
    a_len    = '0;
    s_rvalid = '0;
    s_rlast  = '0;
    s_rdata  = '0;
    s_rresp  = '0;
    m_rready = 1'b0;
    exp_q.delete();
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic push_addr(input logic [2:0] sel, input logic [7:0] len);
    a_fire = 1'b1;
    a_sel  = sel;
    a_len  = len;
    step();
    a_fire = 1'b0;
    $display("[TB] push sel=%0d len=%0d", sel, len);
  endtask

  task automatic set_beat(input int s, input logic [DW-1:0] d, input logic [1:0] r, input logic l);
    s_rdata[s*DW +: DW] = d;
    s_rresp[2*s +: 2]   = r;
    s_rlast[s]          = l;
    s_rvalid[s]         = 1'b1;
  endtask

  task automatic clr_beat(input int s);
    s_rvalid[s] = 1'b0;
    s_rlast[s]  = 1'b0;
  endtask

  // Present one beat on slave s and wait (bounded) for it to be accepted.
  task automatic send_beat(input int s, input logic [DW-1:0] d, input logic [1:0] r, input logic l);
    bit         done;
    logic [4:0] rr;
    done = 1'b0;
    rr   = '0;
    exp_q.push_back('{data: d, resp: r, last: l});
    set_beat(s, d, r, l);
    for (int i = 0; i < 16 && !done; i++) begin
      @(negedge clk);
      if (s_rready[s]) begin
        done = 1'b1;
        rr   = s_rready;
      end
      step();
    end
    clr_beat(s);
    if (done) begin
      check("s_rready_onehot", 64'(rr), 64'(1) << s);
    end else begin
      check("beat_timeout", 64'(0), 64'(1));
      void'(exp_q.pop_back());
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got 0 expected 1");
    $fatal(1, "global timeout");
  end

  initial begin
    reset = 1'b1;
    do_reset();

    // Reset state
    @(negedge clk);
    check("rst_outstanding", 64'(outstanding), 64'd0);
    check("rst_a_full", 64'(a_full), 64'd0);
    check("rst_m_rvalid", 64'(m_rvalid), 64'd0);
    check("rst_s_rready", 64'(s_rready), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    step();

    // 4-beat burst from slave 2
    push_addr(3'd2, 8'd3);
    m_rready = 1'b1;
    @(negedge clk);
    check("t1_outstanding_1", 64'(outstanding), 64'd1);
    step();
    for (int i = 0; i < 4; i++) begin
      send_beat(2, 32'hA0 + 32'(i), 2'(i), (i == 3));
    end
    @(negedge clk);
    check("t1_outstanding_0", 64'(outstanding), 64'd0);
    check("t1_err", 64'(err), 64'd0);
    step();

    // In-order: slave 3 must wait for slave 1
    push_addr(3'd1, 8'd0);
    push_addr(3'd3, 8'd0);
    set_beat(3, 32'hB3, 2'b10, 1'b1);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("t2_hold_rready3", 64'(s_rready[3]), 64'd0);
      check("t2_hold_mvalid", 64'(m_rvalid), 64'd0);
      step();
    end
    send_beat(1, 32'hC1, 2'b01, 1'b1);
    send_beat(3, 32'hB3, 2'b10, 1'b1);
    @(negedge clk);
    check("t2_outstanding_0", 64'(outstanding), 64'd0);
    step();

    // Fill to DEPTH, then overflow
    m_rready = 1'b0;
    for (int i = 0; i < DEPTH; i++) push_addr(3'(i), 8'd0);
    @(negedge clk);
    check("t3_a_full", 64'(a_full), 64'd1);
    check("t3_outstanding_4", 64'(outstanding), 64'd4);
    check("t3_err_before", 64'(err), 64'd0);
    step();
    push_addr(3'd4, 8'd0);
    @(negedge clk);
    check("t3_err_overflow", 64'(err), 64'd1);
    check("t3_outstanding_hold", 64'(outstanding), 64'd4);
    step();
    m_rready = 1'b1;
    for (int i = 0; i < DEPTH; i++) send_beat(i, 32'h30 + 32'(i), 2'(i), 1'b1);
    @(negedge clk);
    check("t3_drained", 64'(outstanding), 64'd0);
    check("t3_a_full_clr", 64'(a_full), 64'd0);
    step();

    // Simultaneous push/pop at count 3 with pointer wrap
    do_reset();
    m_rready = 1'b1;
    push_addr(3'd0, 8'd0);
    push_addr(3'd1, 8'd0);
    push_addr(3'd2, 8'd0);
    exp_q.push_back('{data: 32'h40, resp: 2'b00, last: 1'b1});
    set_beat(0, 32'h40, 2'b00, 1'b1);
    a_fire = 1'b1;
    a_sel  = 3'd4;
    a_len  = 8'd0;
    @(negedge clk);
    check("t4_count3", 64'(outstanding), 64'd3);
    check("t4_rready0", 64'(s_rready), 64'h1);
    step();
    a_fire = 1'b0;
    clr_beat(0);
    @(negedge clk);
    check("t4_pushpop_count", 64'(outstanding), 64'd3);
    check("t4_err", 64'(err), 64'd0);
    step();
    send_beat(1, 32'h41, 2'b00, 1'b1);
    send_beat(2, 32'h42, 2'b01, 1'b1);
    send_beat(4, 32'h44, 2'b11, 1'b1);
    @(negedge clk);
    check("t4_drained", 64'(outstanding), 64'd0);
    step();

    // Full: pop and push in the same cycle -> push dropped, err set
    push_addr(3'd3, 8'd0);
    push_addr(3'd2, 8'd0);
    push_addr(3'd1, 8'd0);
    push_addr(3'd0, 8'd0);
    exp_q.push_back('{data: 32'h53, resp: 2'b00, last: 1'b1});
    set_beat(3, 32'h53, 2'b00, 1'b1);
    a_fire = 1'b1;
    a_sel  = 3'd4;
    @(negedge clk);
    check("t4b_a_full", 64'(a_full), 64'd1);
    step();
    a_fire = 1'b0;
    clr_beat(3);
    @(negedge clk);
    check("t4b_outstanding", 64'(outstanding), 64'd3);
    check("t4b_err", 64'(err), 64'd1);
    step();
    send_beat(2, 32'h52, 2'b00, 1'b1);
    send_beat(1, 32'h51, 2'b00, 1'b1);
    send_beat(0, 32'h50, 2'b00, 1'b1);
    @(negedge clk);
    check("t4b_drained", 64'(outstanding), 64'd0);
    step();

    // Reset mid-burst discards the entry
    push_addr(3'd2, 8'd3);
    m_rready = 1'b1;
    send_beat(2, 32'h70, 2'b00, 1'b0);
    do_reset();
    set_beat(2, 32'h71, 2'b00, 1'b0);
    m_rready = 1'b1;
    @(negedge clk);
    check("t5_rst_outstanding", 64'(outstanding), 64'd0);
    check("t5_rst_s_rready", 64'(s_rready), 64'd0);
    check("t5_rst_m_rvalid", 64'(m_rvalid), 64'd0);
    check("t5_rst_err", 64'(err), 64'd0);
    step();
    clr_beat(2);

    // Out-of-range sel maps to slave 0; master back-pressure holds the beat
    push_addr(3'd6, 8'd0);
    m_rready = 1'b0;
    exp_q.push_back('{data: 32'hD0, resp: 2'b11, last: 1'b1});
    set_beat(0, 32'hD0, 2'b11, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t6_bp_rready", 64'(s_rready), 64'd0);
      check("t6_bp_mvalid", 64'(m_rvalid), 64'd1);
      check("t6_bp_outstanding", 64'(outstanding), 64'd1);
      step();
    end
    m_rready = 1'b1;
    @(negedge clk);
    check("t6_rready0", 64'(s_rready), 64'h1);
    step();
    clr_beat(0);
    @(negedge clk);
    check("t6_popped", 64'(outstanding), 64'd0);
    step();

    // Early rlast on a 2-beat burst
    do_reset();
    m_rready = 1'b1;
    push_addr(3'd1, 8'd1);
    send_beat(1, 32'h60, 2'b00, 1'b1);
    @(negedge clk);
    check("t7_len_err", 64'(err), 64'(LEN_ERR_EXP));
    check("t7_popped", 64'(outstanding), 64'd0);
    step();

    repeat (2) step();
    check("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
